// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: default widths, payload layout and skid-buffer states.
package pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Forwarded fields (dstn, y, regwrite) sit in the low bits so the buffer can slice them out.
  typedef struct packed {
    logic [RW_DEF-1:0]   rs;
    logic [RW_DEF-1:0]   rt;
    logic [XLEN_DEF-1:0] wdata;
    logic                memread;
    logic                memwrite;
    logic                memtoreg;
    logic [RW_DEF-1:0]   dstn;
    logic [XLEN_DEF-1:0] y;
    logic                regwrite;
  } ex_mm_payload_t;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ex_mm_stage_if.sv
// EX -> EX/MEM -> MEM link: input handshake, head-entry outputs and forwarding view.
interface ex_mm_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   dstn_in;
  logic [RW-1:0]   rs_in;
  logic [RW-1:0]   rt_in;
  logic [XLEN-1:0] y_in;
  logic [XLEN-1:0] wdata_in;
  logic            memread_in;
  logic            memwrite_in;
  logic            memtoreg_in;
  logic            regwrite_in;

  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   dstn_out;
  logic [RW-1:0]   rs_out;
  logic [RW-1:0]   rt_out;
  logic [XLEN-1:0] y_out;
  logic [XLEN-1:0] wdata_out;
  logic            memread_out;
  logic            memwrite_out;
  logic            memtoreg_out;
  logic            regwrite_out;

  logic            fwd_valid;
  logic [RW-1:0]   fwd_dstn;
  logic [XLEN-1:0] fwd_y;
  logic [1:0]      occupancy;

  // Environment side: EX producer plus MEM consumer.
  modport master (
    output in_valid, dstn_in, rs_in, rt_in, y_in, wdata_in,
           memread_in, memwrite_in, memtoreg_in, regwrite_in, out_ready,
    input  in_ready, out_valid, dstn_out, rs_out, rt_out, y_out, wdata_out,
           memread_out, memwrite_out, memtoreg_out, regwrite_out,
           fwd_valid, fwd_dstn, fwd_y, occupancy
  );

  // Stage side.
  modport slave (
    input  in_valid, dstn_in, rs_in, rt_in, y_in, wdata_in,
           memread_in, memwrite_in, memtoreg_in, regwrite_in, out_ready,
    output in_ready, out_valid, dstn_out, rs_out, rt_out, y_out, wdata_out,
           memread_out, memwrite_out, memtoreg_out, regwrite_out,
           fwd_valid, fwd_dstn, fwd_y, occupancy
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer (head H, skid S) with registered ready and synchronous flush.
module pipe_skid_buf import pipe_pkg::*; #(
  parameter int W     = 8,
  parameter int FWD_W = W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [FWD_W-1:0] fwd_data,
  output logic [1:0]       occupancy
);

  state_e         state_q, state_d;
  logic [W-1:0]   h_q, h_d;
  logic [W-1:0]   s_q, s_d;
  logic           accept, drain;

  // Ready depends only on state, so MEM stalls never reach EX combinationally.
  assign in_ready  = (state_q != FULL) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_data  = h_q;
  assign fwd_data  = (state_q == FULL) ? s_q[FWD_W-1:0] : h_q[FWD_W-1:0];
  assign occupancy = occ_of(state_q);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          h_d     = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          h_d = in_data;
        end else if (accept) begin
          s_d     = in_data;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          h_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash leaves payload untouched so invalid outputs keep their last value.
    if (flush) begin
      state_d = EMPTY;
      h_d     = h_q;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/ex_mm_stage.sv
// Handshaked EX/MEM stage: packs the EX bundle into a skid buffer, gates control, exports forwarding.
module ex_mm_stage import pipe_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = RW_DEF
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  ex_mm_stage_if.slave  bus
);

  typedef struct packed {
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [XLEN-1:0] wdata;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic [RW-1:0]   dstn;
    logic [XLEN-1:0] y;
    logic            regwrite;
  } payload_t;

  typedef struct packed {
    logic [RW-1:0]   dstn;
    logic [XLEN-1:0] y;
    logic            regwrite;
  } fwd_t;

  payload_t   in_p, head_p;
  fwd_t       fwd_p;
  logic       head_vld, live, ov;
  logic [1:0] occ;

  assign in_p.rs       = bus.rs_in;
  assign in_p.rt       = bus.rt_in;
  assign in_p.wdata    = bus.wdata_in;
  assign in_p.memread  = bus.memread_in;
  assign in_p.memwrite = bus.memwrite_in;
  assign in_p.memtoreg = bus.memtoreg_in;
  assign in_p.dstn     = bus.dstn_in;
  assign in_p.y        = bus.y_in;
  assign in_p.regwrite = bus.regwrite_in;

  pipe_skid_buf #(
    .W     ($bits(payload_t)),
    .FWD_W ($bits(fwd_t))
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_p),
    .out_valid (head_vld),
    .out_ready (bus.out_ready),
    .out_data  (head_p),
    .fwd_data  (fwd_p),
    .occupancy (occ)
  );

  // Registers only clear on the edge, so outputs are also forced low while reset is asserted.
  assign live = ~reset;
  assign ov   = live & head_vld;

  assign bus.out_valid    = ov;
  assign bus.dstn_out     = live ? head_p.dstn  : '0;
  assign bus.rs_out       = live ? head_p.rs    : '0;
  assign bus.rt_out       = live ? head_p.rt    : '0;
  assign bus.y_out        = live ? head_p.y     : '0;
  assign bus.wdata_out    = live ? head_p.wdata : '0;
  assign bus.memread_out  = ov & head_p.memread;
  assign bus.memwrite_out = ov & head_p.memwrite;
  assign bus.memtoreg_out = ov & head_p.memtoreg;
  assign bus.regwrite_out = ov & head_p.regwrite;

  assign bus.fwd_valid = ov & fwd_p.regwrite & (fwd_p.dstn != '0);
  assign bus.fwd_dstn  = live ? fwd_p.dstn : '0;
  assign bus.fwd_y     = live ? fwd_p.y    : '0;
  assign bus.occupancy = live ? occ : 2'd0;

endmodule

// File: tb/tb_ex_mm_stage.sv
// Directed bench for ex_mm_stage: vector table for streaming/stall plus reset, flush, forwarding, bubbles.
module tb_ex_mm_stage;

  logic clk;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  ex_mm_stage_if #(.XLEN(32), .RW(5)) bus ();

  ex_mm_stage #(.XLEN(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        orr;
    logic [4:0]  d;
    logic [31:0] y;
    logic        mw;
    logic        ov;
    logic [31:0] ey;
    logic [4:0]  ed;
    logic        emw;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic iv, logic orr, logic [4:0] d, logic [31:0] y, logic mw,
                              logic ov, logic [31:0] ey, logic [4:0] ed, logic emw,
                              logic [1:0] eocc, logic eir);
    vec_t v;
    v.iv = iv; v.orr = orr; v.d = d; v.y = y; v.mw = mw;
    v.ov = ov; v.ey = ey; v.ed = ed; v.emw = emw; v.eocc = eocc; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic orr, input logic [4:0] d,
                       input logic [31:0] y, input logic mw, input logic rw);
    bus.in_valid    = iv;
    bus.out_ready   = orr;
    bus.dstn_in     = d;
    bus.rs_in       = d;
    bus.rt_in       = d + 5'd1;
    bus.y_in        = y;
    bus.wdata_in    = ~y;
    bus.memread_in  = 1'b0;
    bus.memwrite_in = mw;
    bus.memtoreg_in = 1'b0;
    bus.regwrite_in = rw;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_y_out"},     bus.y_out,          32'd0);
    chk({tag, "_dstn_out"},  32'(bus.dstn_out),  32'd0);
    chk({tag, "_memwrite"},  32'(bus.memwrite_out), 32'd0);
    chk({tag, "_fwd_valid"}, 32'(bus.fwd_valid), 32'd0);
    chk({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
  endtask

  task automatic drain_all();
    drive(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
    cyc();
    cyc();
  endtask

  initial begin
    // streaming with out_ready high
    tbl[0]  = mk(1, 1, 5'd1, 32'h10, 0,  1, 32'h10, 5'd1, 0, 2'd1, 1);
    tbl[1]  = mk(1, 1, 5'd2, 32'h20, 0,  1, 32'h20, 5'd2, 0, 2'd1, 1);
    tbl[2]  = mk(1, 1, 5'd3, 32'h30, 0,  1, 32'h30, 5'd3, 0, 2'd1, 1);
    tbl[3]  = mk(1, 1, 5'd4, 32'h40, 0,  1, 32'h40, 5'd4, 0, 2'd1, 1);
    tbl[4]  = mk(0, 1, 5'd0, 32'h0,  0,  0, 32'h40, 5'd4, 0, 2'd0, 1);
    // stall for 3 cycles, then release
    tbl[5]  = mk(1, 0, 5'd5, 32'hA,  0,  1, 32'hA,  5'd5, 0, 2'd1, 1);
    tbl[6]  = mk(1, 0, 5'd6, 32'hB,  0,  1, 32'hA,  5'd5, 0, 2'd2, 0);
    tbl[7]  = mk(1, 0, 5'd7, 32'hC,  1,  1, 32'hA,  5'd5, 0, 2'd2, 0);
    tbl[8]  = mk(1, 1, 5'd7, 32'hC,  1,  1, 32'hB,  5'd6, 0, 2'd1, 1);
    tbl[9]  = mk(1, 1, 5'd7, 32'hC,  1,  1, 32'hC,  5'd7, 1, 2'd1, 1);
    tbl[10] = mk(0, 1, 5'd0, 32'h0,  1,  0, 32'hC,  5'd7, 0, 2'd0, 1);

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 32'h55, 1'b1, 1'b1);
    cyc();
    chk_zero("rst1");
    cyc();
    chk_zero("rst2");
    reset = 1'b0;
    drive(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_y_out",     bus.y_out,          32'd0);
    chk("post_rst_occupancy", 32'(bus.occupancy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].orr, tbl[i].d, tbl[i].y, tbl[i].mw, 1'b1);
      cyc();
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid),    32'(tbl[i].ov));
      chk($sformatf("v%0d_y_out", i),     bus.y_out,             tbl[i].ey);
      chk($sformatf("v%0d_wdata_out", i), bus.wdata_out,         ~tbl[i].ey);
      chk($sformatf("v%0d_dstn_out", i),  32'(bus.dstn_out),     32'(tbl[i].ed));
      chk($sformatf("v%0d_rs_out", i),    32'(bus.rs_out),       32'(tbl[i].ed));
      chk($sformatf("v%0d_memwrite", i),  32'(bus.memwrite_out), 32'(tbl[i].emw));
      chk($sformatf("v%0d_regwrite", i),  32'(bus.regwrite_out), 32'(tbl[i].ov));
      chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy),    32'(tbl[i].eocc));
      chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),     32'(tbl[i].eir));
    end

    // flush while FULL with a simultaneous accept
    drive(1'b1, 1'b0, 5'd8, 32'h111, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 5'd9, 32'h222, 1'b1, 1'b1);
    cyc();
    chk("fl_pre_occupancy", 32'(bus.occupancy), 32'd2);
    flush = 1'b1;
    drive(1'b1, 1'b0, 5'd10, 32'h333, 1'b1, 1'b1);
    cyc();
    flush = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid),    32'd0);
    chk("fl_memwrite",  32'(bus.memwrite_out), 32'd0);
    chk("fl_occupancy", 32'(bus.occupancy),    32'd0);
    chk("fl_in_ready",  32'(bus.in_ready),     32'd1);
    drive(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
    cyc();
    chk("fl_after_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_after_occupancy", 32'(bus.occupancy), 32'd0);
    chk("fl_after_y_hold",    bus.y_out,          32'h111);

    // forwarding from H then from S
    drive(1'b1, 1'b0, 5'd3, 32'd5, 1'b0, 1'b1);
    cyc();
    chk("fwdH_valid", 32'(bus.fwd_valid), 32'd1);
    chk("fwdH_dstn",  32'(bus.fwd_dstn),  32'd3);
    chk("fwdH_y",     bus.fwd_y,          32'd5);
    drive(1'b1, 1'b0, 5'd7, 32'd9, 1'b0, 1'b1);
    cyc();
    chk("fwdS_valid", 32'(bus.fwd_valid), 32'd1);
    chk("fwdS_dstn",  32'(bus.fwd_dstn),  32'd7);
    chk("fwdS_y",     bus.fwd_y,          32'd9);
    chk("fwdS_head_y", bus.y_out,         32'd5);
    drain_all();
    chk("fwd_empty_valid", 32'(bus.fwd_valid), 32'd0);

    drive(1'b1, 1'b0, 5'd3, 32'd5, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 5'd0, 32'd9, 1'b0, 1'b1);
    cyc();
    chk("fwd_dstn0_valid", 32'(bus.fwd_valid), 32'd0);
    drain_all();

    drive(1'b1, 1'b0, 5'd3, 32'd5, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 5'd7, 32'd9, 1'b0, 1'b0);
    cyc();
    chk("fwd_rw0_valid", 32'(bus.fwd_valid), 32'd0);
    drain_all();

    // bubbles carrying memwrite must not reach MEM
    drive(1'b0, 1'b1, 5'd2, 32'h77, 1'b1, 1'b1);
    cyc();
    chk("bub1_memwrite",  32'(bus.memwrite_out), 32'd0);
    chk("bub1_out_valid", 32'(bus.out_valid),    32'd0);
    cyc();
    chk("bub2_memwrite",  32'(bus.memwrite_out), 32'd0);
    chk("bub2_out_valid", 32'(bus.out_valid),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
